// File: rtl/dcache_line_sequencer.sv
// Line-to-word sequencer between the dcache controller and the word memory port.
// Splits refill/write-back lines into LINE_WORDS handshaked word transactions.
module dcache_line_sequencer #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       line_req,
  output logic                       line_ready,
  input  logic                       line_we,
  input  logic [31:0]                line_addr,
  input  logic [LINE_WORDS*32-1:0]   line_wdata,
  output logic [LINE_WORDS*32-1:0]   line_rdata,
  output logic                       line_done,
  output logic                       line_err,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_ready,
  input  logic [31:0]                mem_rdata
);

  localparam int unsigned     IDXW     = $clog2(LINE_WORDS);
  localparam int unsigned     TMOW     = $clog2(TIMEOUT);
  localparam logic [31:0]     OFF_MASK = 32'(LINE_WORDS * 4 - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(LINE_WORDS - 1);
  localparam logic [TMOW-1:0] TMO_LAST = TMOW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t                        state_q, state_nx;
  logic [IDXW-1:0]               idx_q, idx_nx;
  logic [TMOW-1:0]               tmo_q, tmo_nx;
  logic                          err_q, err_nx;
  logic                          we_q, we_nx;
  logic [31:0]                   base_q, base_nx;
  logic [LINE_WORDS-1:0][31:0]   wbuf_q, wbuf_nx;
  logic [LINE_WORDS-1:0][31:0]   rbuf_q;
  logic                          capture;
  logic                          rd_store;

  logic                          line_ready_q;
  logic                          line_done_q;
  logic                          line_err_q;
  logic                          mem_req_q;
  logic                          mem_we_q;
  logic [31:0]                   mem_addr_q;
  logic [31:0]                   mem_wdata_q;

  always_comb begin
    state_nx = state_q;
    idx_nx   = idx_q;
    tmo_nx   = tmo_q;
    err_nx   = err_q;
    capture  = 1'b0;
    rd_store = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (line_req) begin
          capture  = 1'b1;
          idx_nx   = '0;
          tmo_nx   = '0;
          err_nx   = 1'b0;
          state_nx = ST_XFER;
        end
      end
      ST_XFER: begin
        if (mem_ready) begin
          rd_store = ~we_q;
          if (idx_q == IDX_LAST) begin
            state_nx = ST_DONE;
          end else begin
            idx_nx   = idx_q + 1'b1;
            state_nx = ST_GAP;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_nx   = 1'b1;
          state_nx = ST_DONE;
        end else begin
          tmo_nx = tmo_q + 1'b1;
        end
      end
      ST_GAP: begin
        tmo_nx   = '0;
        state_nx = ST_XFER;
      end
      ST_DONE: begin
        err_nx   = 1'b0;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    we_nx   = capture ? line_we                 : we_q;
    base_nx = capture ? (line_addr & ~OFF_MASK) : base_q;
    wbuf_nx = capture ? line_wdata              : wbuf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      base_q  <= '0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_nx;
      idx_q   <= idx_nx;
      tmo_q   <= tmo_nx;
      err_q   <= err_nx;
      we_q    <= we_nx;
      base_q  <= base_nx;
      wbuf_q  <= wbuf_nx;
      if (rd_store) begin
        rbuf_q[idx_q] <= mem_rdata;
      end
    end
  end

  // Outputs are registered from the next-state values so they change on the
  // same edge as the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_ready_q <= 1'b1;
      line_done_q  <= 1'b0;
      line_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      line_ready_q <= (state_nx == ST_IDLE);
      line_done_q  <= (state_nx == ST_DONE);
      line_err_q   <= (state_nx == ST_DONE) && err_nx;
      mem_req_q    <= (state_nx == ST_XFER);
      mem_we_q     <= (state_nx == ST_XFER) && we_nx;
      if (state_nx == ST_XFER) begin
        mem_addr_q  <= base_nx + {{(30 - IDXW){1'b0}}, idx_nx, 2'b00};
        mem_wdata_q <= wbuf_nx[idx_nx];
      end
    end
  end

  assign line_ready = line_ready_q;
  assign line_done  = line_done_q;
  assign line_err   = line_err_q;
  assign line_rdata = rbuf_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dcache_line_sequencer.sv
// Bench for dcache_line_sequencer: behavioural word memory plus a line-level
// reference model (flat memory image, expected word sequence and done timing).
module tb_dcache_line_sequencer;

  localparam int W   = 4;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          line_req;
  logic          line_ready;
  logic          line_we;
  logic [31:0]   line_addr;
  logic [127:0]  line_wdata;
  logic [127:0]  line_rdata;
  logic          line_done;
  logic          line_err;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic [31:0]   mem_rdata;

  dcache_line_sequencer #(.LINE_WORDS(W), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_req   (line_req),
    .line_ready (line_ready),
    .line_we    (line_we),
    .line_addr  (line_addr),
    .line_wdata (line_wdata),
    .line_rdata (line_rdata),
    .line_done  (line_done),
    .line_err   (line_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- word memory: ready 'lat' cycles after req seen ----------
  typedef struct packed {logic [31:0] a; logic we; logic [31:0] d;} txn_t;
  txn_t        log_q[$];
  logic [31:0] mem [1024];
  bit          mem_inited = 1'b0;
  int          lat = 10;
  bit          mute = 1'b0;
  logic        spur = 1'b0;
  bit          busy;
  int          cnt;
  int          stab_bad = 0;
  logic        rdy_q;
  logic [31:0] rdat_q;
  logic [31:0] s_addr, s_wdata;
  logic        s_we;

  assign mem_ready = rdy_q | spur;
  assign mem_rdata = rdat_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= 0;
      rdy_q <= 1'b0;
      if (!mem_inited) begin
        for (int i = 0; i < 1024; i++) mem[i] <= 32'(i);
        mem_inited <= 1'b1;
      end
    end else begin
      rdy_q  <= 1'b0;
      rdat_q <= $urandom;
      if (busy) begin
        if (mem_req !== 1'b1 || mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wdata)
          stab_bad <= stab_bad + 1;
        if (cnt >= lat - 1) begin
          rdy_q <= 1'b1;
          busy  <= 1'b0;
          if (s_we) mem[s_addr[11:2]] <= s_wdata;
          else      rdat_q <= mem[s_addr[11:2]];
        end else begin
          cnt <= cnt + 1;
        end
      end else if (mem_req === 1'b1 && !rdy_q && !mute) begin
        log_q.push_back({mem_addr, mem_we, mem_wdata});
        s_addr  <= mem_addr;
        s_we    <= mem_we;
        s_wdata <= mem_wdata;
        if (lat <= 1) begin
          rdy_q <= 1'b1;
          if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
          else        rdat_q <= mem[mem_addr[11:2]];
        end else begin
          busy <= 1'b1;
          cnt  <= 1;
        end
      end
    end
  end

  // ---------------- reference model state and checking ----------------------
  logic [31:0]        ref_mem [1024];
  logic [W-1:0][31:0] exp_rdata;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic we, input logic [31:0] addr, input logic [127:0] wd,
                        output int a);
    log_q.delete();
    chk("ready_before_req", 128'(line_ready), 128'(1));
    line_we    = we;
    line_addr  = addr;
    line_wdata = wd;
    line_req   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = cyc;
  endtask

  task automatic finish_line(input int a, input logic we, input logic [31:0] addr,
                             input logic [127:0] wd, input bit keep_req);
    int          done_at;
    int          exp_at;
    bit          busy_rdy;
    logic        err_seen;
    logic [31:0] base;
    done_at  = -1;
    busy_rdy = 1'b0;
    err_seen = 1'bx;
    if (!keep_req) line_req = 1'b0;
    base   = addr & ~32'hF;
    exp_at = mute ? a + TMO : a + (W - 1) * (lat + 2) + lat + 1;
    for (int n = 0; n < 2000 && done_at < 0; n++) begin
      if (line_done === 1'b1) begin
        done_at  = cyc;
        err_seen = line_err;
      end else begin
        if (line_ready !== 1'b0) busy_rdy = 1'b1;
        @(negedge clk);
      end
    end
    chk("done_seen", 128'(done_at >= 0), 128'(1));
    chk("done_edge", 128'(done_at), 128'(exp_at));
    chk("line_err", 128'(err_seen), 128'(mute));
    chk("mem_req_at_done", 128'(mem_req), 128'(0));
    chk("ready_at_done", 128'(line_ready), 128'(0));
    chk("ready_low_while_busy", 128'(busy_rdy), 128'(0));
    if (!mute) begin
      for (int i = 0; i < W; i++) begin
        if (we) ref_mem[(base[11:2] + i) % 1024] = wd[32*i +: 32];
        else    exp_rdata[i] = ref_mem[(base[11:2] + i) % 1024];
      end
      chk("word_count", 128'(log_q.size()), 128'(W));
      for (int i = 0; i < W; i++) begin
        if (i < log_q.size()) begin
          chk("word_addr", 128'(log_q[i].a), 128'(base + 32'(4 * i)));
          chk("word_we", 128'(log_q[i].we), 128'(we));
          chk("word_wdata", 128'(log_q[i].d), 128'(wd[32*i +: 32]));
        end
      end
    end
    chk("line_rdata", line_rdata, exp_rdata);
    chk("req_stable", 128'(stab_bad), 128'(0));
    @(negedge clk);
    chk("done_one_cycle", 128'(line_done), 128'(0));
    chk("idle_after_done", 128'(line_ready), 128'(1));
    chk("req_low_after_done", 128'(mem_req), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          a;
    int          a2;
    bit          pulsed;
    logic [127:0] d1, d2, wd;
    logic [31:0]  ad;
    logic         we;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(i);
    exp_rdata  = '0;
    rst_n      = 1'b0;
    line_req   = 1'b0;
    line_we    = 1'b0;
    line_addr  = '0;
    line_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_line_ready", 128'(line_ready), 128'(1));
    chk("rst_mem_req", 128'(mem_req), 128'(0));
    chk("rst_mem_we", 128'(mem_we), 128'(0));
    chk("rst_line_done", 128'(line_done), 128'(0));
    chk("rst_line_err", 128'(line_err), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_mem_wdata", 128'(mem_wdata), 128'(0));
    chk("rst_line_rdata", line_rdata, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Refill 0x40 with latency 10.
    lat = 10;
    launch(1'b0, 32'h0000_0040, '0, a);
    finish_line(a, 1'b0, 32'h0000_0040, '0, 1'b0);
    chk("refill_40_data", line_rdata, 128'h00000013_00000012_00000011_00000010);

    // Unaligned write-back then read it back.
    d1 = 128'h000000DD_000000CC_000000BB_000000AA;
    launch(1'b1, 32'h0000_0107, d1, a);
    finish_line(a, 1'b1, 32'h0000_0107, d1, 1'b0);
    launch(1'b0, 32'h0000_0100, '0, a);
    finish_line(a, 1'b0, 32'h0000_0100, '0, 1'b0);
    chk("readback_100", line_rdata, d1);

    // line_req held high, wdata changed mid-line: one line per IDLE visit.
    lat = 3;
    d1  = 128'h11111111_22222222_33333333_44444444;
    d2  = 128'h55555555_66666666_77777777_88888888;
    launch(1'b1, 32'h0000_0200, d1, a);
    repeat (3) @(negedge clk);
    line_wdata = d2;
    finish_line(a, 1'b1, 32'h0000_0200, d1, 1'b1);
    log_q.delete();
    @(negedge clk);
    a2 = cyc;
    chk("hold_reaccept", 128'(line_ready), 128'(0));
    finish_line(a2, 1'b1, 32'h0000_0200, d2, 1'b0);

    // Memory never answers: abort after TIMEOUT cycles.
    mute = 1'b1;
    launch(1'b0, 32'h0000_0300, '0, a);
    finish_line(a, 1'b0, 32'h0000_0300, '0, 1'b0);
    mute = 1'b0;

    // Reset during word 2 of a refill.
    lat = 10;
    launch(1'b0, 32'h0000_0080, '0, a);
    line_req = 1'b0;
    for (int n = 0; n < 500 && log_q.size() < 3; n++) @(negedge clk);
    chk("reached_word2", 128'(log_q.size()), 128'(3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", 128'(mem_req), 128'(0));
    chk("async_rst_ready", 128'(line_ready), 128'(1));
    chk("async_rst_done", 128'(line_done), 128'(0));
    exp_rdata = '0;
    chk("async_rst_rdata", line_rdata, exp_rdata);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    pulsed = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (line_done !== 1'b0 || mem_req !== 1'b0) pulsed = 1'b1;
    end
    chk("no_activity_after_rst", 128'(pulsed), 128'(0));
    launch(1'b0, 32'h0000_0040, '0, a);
    finish_line(a, 1'b0, 32'h0000_0040, '0, 1'b0);
    chk("refill_40_after_rst", line_rdata, 128'h00000013_00000012_00000011_00000010);

    // Spurious mem_ready while idle.
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (2) @(negedge clk);
    chk("spur_ready", 128'(line_ready), 128'(1));
    chk("spur_mem_req", 128'(mem_req), 128'(0));
    chk("spur_done", 128'(line_done), 128'(0));
    chk("spur_rdata", line_rdata, exp_rdata);

    // Randomized lines against the model.
    for (int k = 0; k < 16; k++) begin
      we  = 1'($urandom_range(0, 1));
      ad  = $urandom & 32'h0000_0FFF;
      wd  = {$urandom, $urandom, $urandom, $urandom};
      lat = $urandom_range(1, 6);
      launch(we, ad, wd, a);
      finish_line(a, we, ad, wd, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
